bsg_link_osdr_tx: RTL

Source-synchronous single-data-rate link transmitter. It accepts words from the core over a valid/ready-and handshake and launches them through registered output flops alongside a forwarded, edge-centred clock. It enforces credit-based flow control using tokens returned by the far-end receiver, and sequences a link-reset pulse after local reset. It sits at the transmit pad side of the I/O ring, paired with the far-end input SDR capture PHY.

---
 rtl/bsg_link_sdr_pkg.sv | 19 +
 rtl/bsg_link_osdr_phy.sv | 55 +++++
 rtl/bsg_link_osdr_tx.sv | 110 +++++++++++
 3 files changed

// File: rtl/bsg_link_sdr_pkg.sv
// Shared definitions for the source-synchronous SDR link.
//   state_e            : transmitter sequencing state (link held in reset, or active)
//   credit_width_f()   : width of a credit counter able to hold 0..2^lg_credit inclusive
package bsg_link_sdr_pkg;

    typedef enum logic {
        S_HOLD   = 1'b0,
        S_ACTIVE = 1'b1
    } state_e;

    localparam int HOLD_CNT_W = 8;

    // The counter must represent the full buffer depth, not just depth-1,
    // so one extra bit beyond lg_credit is required.
    function automatic int credit_width_f(input int lg_credit);
        return lg_credit + 1;
    endfunction

endpackage

// File: rtl/bsg_link_osdr_phy.sv
// Output PHY for the SDR link transmitter: the forwarded clock inverter and the
// per-bit launch flops that drive the pads.
//   clk_i, reset_i  : core clock, asynchronous active-high reset
//   v_d             : next value of link_v_o
//   data_en, data_d : load enable and next value of link_data_o
//   link_reset_d    : next value of link_reset_o
//   link_clk_o      : inverted clk_i, so its falling edge coincides with launch
//   link_v_o, link_data_o, link_reset_o : registered pad outputs
module bsg_link_osdr_phy #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_d,
    input  logic               data_en,
    input  logic [width_p-1:0] data_d,
    input  logic               link_reset_d,
    output logic               link_clk_o,
    output logic               link_v_o,
    output logic [width_p-1:0] link_data_o,
    output logic               link_reset_o
);

    // Forwarded clock: rising edge falls in the middle of each data eye.
    assign link_clk_o = ~clk_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            link_v_o <= 1'b0;
        end else begin
            link_v_o <= v_d;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            link_reset_o <= 1'b1;
        end else begin
            link_reset_o <= link_reset_d;
        end
    end

    // One flop per data bit; idle cycles keep the previous word on the pads
    // so the bus does not toggle when nothing is sent.
    for (genvar gi = 0; gi < width_p; gi++) begin : g_data_bit
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                link_data_o[gi] <= 1'b0;
            end else if (data_en) begin
                link_data_o[gi] <= data_d[gi];
            end
        end
    end

endmodule

// File: rtl/bsg_link_osdr_tx.sv
// Source-synchronous SDR link transmitter with credit-based flow control.
//   clk_i, reset_i     : core clock, asynchronous active-high reset
//   v_i, data_i        : core word offered; accepted when v_i & ready_and_o
//   ready_and_o        : registered-state-only ready (link active and credits left)
//   token_i            : one-cycle credit return from the far-end receiver
//   link_clk_o         : forwarded (inverted) clock
//   link_v_o, link_data_o, link_reset_o : registered link outputs
//   credit_err_o       : sticky flag, token returned while credits were full
module bsg_link_osdr_tx
    import bsg_link_sdr_pkg::*;
#(
    parameter int width_p        = 8,
    parameter int lg_credit_p    = 3,
    parameter int reset_cycles_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_and_o,
    input  logic               token_i,
    output logic               link_clk_o,
    output logic               link_v_o,
    output logic [width_p-1:0] link_data_o,
    output logic               link_reset_o,
    output logic               credit_err_o
);

    localparam int CREDIT_W = credit_width_f(lg_credit_p);
    localparam logic [CREDIT_W-1:0]   CREDIT_MAX = CREDIT_W'(1 << lg_credit_p);
    localparam logic [HOLD_CNT_W-1:0] HOLD_INIT  = HOLD_CNT_W'(reset_cycles_p - 1);

    state_e                  state_reg,   state_next;
    logic [HOLD_CNT_W-1:0]   counter_reg, counter_next;
    logic [CREDIT_W-1:0]     credits_reg, credits_next;
    logic                    err_reg,     err_next;
    logic                    send;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg   <= S_HOLD;
            counter_reg <= HOLD_INIT;
            credits_reg <= CREDIT_MAX;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            credits_reg <= credits_next;
            err_reg     <= err_next;
        end
    end

    assign ready_and_o  = (state_reg == S_ACTIVE) && (credits_reg != '0);
    assign send         = v_i & ready_and_o;
    assign credit_err_o = err_reg;

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        case (state_reg)
            S_HOLD: begin
                if (counter_reg == '0) begin
                    state_next = S_ACTIVE;
                end else begin
                    counter_next = counter_reg - 1'b1;
                end
            end
            S_ACTIVE: begin
                state_next = S_ACTIVE;
            end
            default: begin
                state_next = S_HOLD;
            end
        endcase
    end

    // Tokens during hold are necessarily overflows since no word has been sent,
    // so the same saturate-and-flag rule covers both states.
    always_comb begin
        credits_next = credits_reg;
        err_next     = err_reg;
        if (send && !token_i) begin
            credits_next = credits_reg - 1'b1;
        end else if (token_i && !send) begin
            if (credits_reg == CREDIT_MAX) begin
                err_next = 1'b1;
            end else begin
                credits_next = credits_reg + 1'b1;
            end
        end
    end

    // link_reset_o follows the next state so it drops on the same edge that
    // makes ready_and_o rise.
    bsg_link_osdr_phy #(
        .width_p(width_p)
    ) phy (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .v_d          (send),
        .data_en      (send),
        .data_d       (data_i),
        .link_reset_d (state_next == S_HOLD),
        .link_clk_o   (link_clk_o),
        .link_v_o     (link_v_o),
        .link_data_o  (link_data_o),
        .link_reset_o (link_reset_o)
    );

endmodule
